// File: rtl/instr_encoder_32.sv
// MIPS-32 instruction encoder and program loader: packs decoded fields into
// machine words and writes them to consecutive instruction-memory addresses.
module instr_encoder_32 #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err_illegal_op
);

    typedef enum logic {IDLE, WRITE} state_t;

    localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   count_inc;
    logic [31:0]       word;
    logic              legal;
    logic              accept;

    assign count_inc = count + (ADDR_W+1)'(1);

    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (in_op)
            4'd0:    word = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
            4'd1:    word = {6'b100011, in_rs, in_rt, in_imm};
            4'd2:    word = {6'b101011, in_rs, in_rt, in_imm};
            4'd3:    word = {6'b000100, in_rs, in_rt, in_imm};
            4'd4:    word = {6'b001000, in_rs, in_rt, in_imm};
            4'd5:    word = {6'b000010, in_target};
            // jr is an R-type with funct 0x08 and only rs meaningful
            4'd6:    word = {6'b000000, in_rs, 15'b0, 6'b001000};
            4'd7:    word = {6'b000011, in_target};
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        mem_we     = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !full && !start;
                accept   = in_valid && in_ready;
                if (accept && legal) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                mem_we     = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // A start during WRITE lets the pending write finish, then discards its count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr            <= BASE_ADDR;
            mem_addr       <= BASE_ADDR;
            mem_wdata      <= '0;
            count          <= '0;
            full           <= 1'b0;
            err_illegal_op <= 1'b0;
        end else if (start) begin
            ptr            <= BASE_ADDR;
            count          <= '0;
            full           <= 1'b0;
            err_illegal_op <= 1'b0;
        end else if (state == WRITE) begin
            ptr   <= ptr + ADDR_W'(1);
            count <= count_inc;
            full  <= (count_inc == CAPACITY);
        end else if (accept) begin
            if (legal) begin
                mem_addr  <= ptr;
                mem_wdata <= word;
            end else begin
                err_illegal_op <= 1'b1;
            end
        end
    end

endmodule

// File: doc/instr_encoder_32.md
# instr_encoder_32

Sequential MIPS-32 instruction encoder and program loader. It accepts decoded instruction fields over a valid/ready handshake and packs them into 32-bit machine words. It writes each word to consecutive instruction-memory addresses. It produces exactly the opcode and field encodings that the control decoder in the single-cycle core consumes, and it is used to load test programs into instruction memory before the core runs.

## Interface
Parameters:
- ADDR_W, 8, word-address width of instruction memory; capacity is 2^ADDR_W words.
- BASE_ADDR, 0, word address of the first write after reset or start.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  synchronous restart: pointer to BASE_ADDR, clears full and err_illegal_op.
- in_valid  input  1  field set on in_* is valid.
- in_ready  output  1  encoder can accept a field set this cycle.
- in_op  input  4  mnemonic: 0 R-type, 1 lw, 2 sw, 3 beq, 4 addi, 5 j, 6 jr, 7 jal; 8-15 illegal.
- in_rs, in_rt, in_rd, in_shamt  input  5 each  register and shift fields.
- in_funct  input  6  R-type function field.
- in_imm  input  16  I-type immediate, used verbatim.
- in_target  input  26  J-type word target.
- mem_we  output  1  one-cycle write strobe to instruction memory.
- mem_addr  output  ADDR_W  word write address.
- mem_wdata  output  32  encoded instruction.
- count  output  ADDR_W+1  words written since reset or start.
- full  output  1  capacity reached; no further accepts.
- err_illegal_op  output  1  sticky; an illegal in_op was presented.

## Operation
- Encodings:
  - R-type: {6'b000000, rs, rt, rd, shamt, funct}.
  - lw, sw, beq, addi: {op, rs, rt, imm}, with op = 100011, 101011, 000100 and 001000 respectively.
  - j: {000010, target}.
  - jal: {000011, target}.
  - jr: {000000, rs, 15'b0, 001000}. rt, rd, shamt and funct are ignored for jr.
- Unused input fields are ignored.
- States:
  - IDLE: in_ready = !full && !start. On in_valid && in_ready:
    - legal op: register the encoded word, go to WRITE.
    - illegal op: set err_illegal_op, drop the field set, stay in IDLE, no write.
  - WRITE: mem_we = 1, mem_addr = pointer, in_ready = 0. At the end of the cycle, pointer and count increment and the state returns to IDLE. If count reaches 2^ADDR_W, full is set.
- Pointer wraps modulo 2^ADDR_W. Wrap-around never causes an overwrite, because full blocks further accepts.
- start in IDLE: pointer = BASE_ADDR, count = 0, full = 0, err_illegal_op = 0. in_ready is forced low that cycle, so start wins over a simultaneous accept.
- start in WRITE: the pending write still completes at the old pointer. The clear then takes effect, so pointer = BASE_ADDR and count = 0 (the just-written word is not counted).
- Reset values, asynchronous: state IDLE, in_ready 1, mem_we 0, mem_addr BASE_ADDR, mem_wdata 0, count 0, full 0, err_illegal_op 0.
- Reset asserted during WRITE drops mem_we immediately, and the write is lost.

## Timing
- Cycle N: handshake (in_valid && in_ready).
- Cycle N+1: mem_we = 1 with mem_addr and mem_wdata stable. in_ready = 0.
- Cycle N+2: count updated. in_ready = 1 unless full.
- Maximum throughput: one word per 2 cycles.
- An illegal op is consumed in one cycle. err_illegal_op is high from cycle N+1 and stays high until start or reset.
- mem_addr and mem_wdata are registered and hold their last value when mem_we = 0.
- full rises on the same edge that count reaches 2^ADDR_W, so in_ready is already low in the following cycle.

## Test plan
- Reset and then idle for 5 cycles: all outputs at their reset values, mem_we never asserted.
- Send lw (rs 9, rt 8, imm 4), then sw (same fields), then addi (rs 0, rt 2, imm 5) back-to-back with in_valid held high:
  - words 0x8D280004, 0xAD280004 and 0x20020005 written at addresses 0, 1, 2.
  - in_ready toggles 1,0,1,0.
  - count ends at 3.
- Send R-type add (rs 1, rt 2, rd 3, funct 0x20), beq (rs 1, rt 2, imm 0xFFFF), j 0x10, jal 0x10, jr rs 31:
  - written words are 0x00221820, 0x1022FFFF, 0x08000010, 0x0C000010, 0x03E00008.
  - jr output unchanged when junk is driven on rt, rd and funct.
- in_op = 12 between two legal ops:
  - err_illegal_op = 1 from the next cycle.
  - no mem_we for the illegal op.
  - the following legal op writes to the next sequential address.
- ADDR_W = 2, five legal ops:
  - addresses 0-3 written; full = 1 and count = 4 after the fourth write.
  - the fifth op is never accepted.
  - pulse start: full = 0, count = 0, err_illegal_op = 0, and the next op writes address 0.
- Fault cases:
  - rst_n low in a WRITE cycle: mem_we drops with no clock edge, and count = 0 after release.
  - start coincident with in_valid in IDLE: no accept.
